change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream completion stage for the coin-credit FSM. It consumes the credit block's `dispense`, `collect` and `amount` outputs. On each new vend it drives the drink motor for a fixed time, then pays out change one coin at a time through a request/acknowledge handshake with the coin hopper. Finally it issues a one-cycle `clear_credit` pulse, which the system uses to return the credit FSM to zero.

## Interface
- `PRICE_UNITS`, default 6: drink price in 5-cent units (30 c).
- `MOTOR_CYCLES`, default 8: cycles `vend_motor` is held high; legal range 1..255.
- `ACK_TIMEOUT`, default 255: cycles to wait for `hopper_ack` before faulting; legal range 1..255.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `dispense`, input, 1: vend request level from the credit FSM.
- `collect`, input, 1: change-owed level from the credit FSM.
- `amount`, input, 4: credited value in 5-cent units (0..15).
- `hopper_ack`, input, 1: one-cycle acknowledge that the requested coin was ejected.
- `vend_motor`, output, 1: drink motor drive.
- `eject_dime`, output, 1: request hopper to eject one dime.
- `eject_nickel`, output, 1: request hopper to eject one nickel.
- `busy`, output, 1: high in every state except IDLE.
- `clear_credit`, output, 1: one-cycle pulse at transaction end.
- `change_err`, output, 1: sticky hopper-timeout / illegal-amount flag.

## Operation
- States: IDLE, VEND, REQ, WAIT, DONE.
- Vend start:
  - `dispense` is registered every cycle into `disp_q`.
  - A vend starts only when IDLE and `dispense & ~disp_q` (rising edge).
  - `dispense` held high does not retrigger.
- Latch at vend start:
  - `change = collect ? amount - PRICE_UNITS : 0`, 4-bit unsigned.
  - If `collect` and `amount < PRICE_UNITS`: `change = 0` and `change_err` is set.
  - Next state is VEND.
- VEND:
  - `vend_motor` = 1; 8-bit counter runs from 0 to `MOTOR_CYCLES`-1.
  - At terminal count: go to REQ if `change != 0`, else DONE.
- REQ (one cycle, no outputs): selects the coin.
  - `change >= 2`: dime.
  - otherwise: nickel.
  - Next state is WAIT; the timeout counter is cleared.
- WAIT:
  - Exactly one of `eject_dime` / `eject_nickel` is high, held until ack or timeout.
  - On `hopper_ack`: `change` decreases by 2 (dime) or 1 (nickel), never below 0. Go to REQ if the new `change != 0`, else DONE.
  - On timeout (`ACK_TIMEOUT` cycles without ack): set `change_err`, abandon remaining change, go to DONE.
- DONE: `clear_credit` = 1 for one cycle, then IDLE.
- `hopper_ack` outside WAIT is ignored.
- `dispense` edges while `busy` are ignored; they are not queued.
- `change_err` clears only on `rst` or at the next vend start.
- Change encoding for the default price:
  - `amount` 6 → 0 coins.
  - `amount` 7 → N.
  - `amount` 8 → D.
  - `amount` 9 → D, N.
  - `amount` 10 → D, D.

## Timing
- Reset values: all outputs 0, state IDLE, `disp_q` 0, counters 0.
- Reset is asynchronous and takes effect mid-transaction. Motor and eject requests drop immediately, and no `clear_credit` is issued.
- All outputs are registered (Moore); none is combinational from inputs.
- Edge at sample cycle N:
  - `busy` and `vend_motor` are high from N+1.
  - `vend_motor` stays high for exactly `MOTOR_CYCLES` cycles (N+1..N+MOTOR_CYCLES).
- After VEND, REQ occupies one cycle, so an eject request rises 2 cycles after the motor falls.
- Request deasserts the cycle after `hopper_ack` is sampled high.
- There is at least one cycle (REQ) of zero requests between consecutive coins.
- `eject_dime` and `eject_nickel` are never simultaneously high.
- If `hopper_ack` arrives in the same cycle as timeout expiry, the ack wins: change is counted and there is no error.
- No-change transaction latency: `clear_credit` occurs at cycle N+MOTOR_CYCLES+1; `busy` drops the following cycle.

## Test plan
- Exact credit: `amount`=6, `collect`=0, `dispense` 0→1. Expect:
  - `vend_motor` high 8 cycles.
  - no eject requests.
  - `clear_credit` pulse at N+9.
  - `change_err` 0.
- Change 35 c: `amount`=7, `collect`=1; ack 3 cycles after request. Expect one `eject_nickel` held 3 cycles, then a single `clear_credit`.
- Change 50 c: `amount`=10, `collect`=1, immediate acks. Expect two `eject_dime` pulses separated by ≥1 idle cycle; no nickel.
- Hopper stall: `amount`=8, `collect`=1, `hopper_ack` never asserted. Expect:
  - `eject_dime` high for 255 cycles.
  - `change_err`=1, then `clear_credit`.
  - `change_err` stays 1 until the next vend start.
- Retrigger/hold: `dispense` held high 50 cycles, plus a second rising edge during VEND. Expect exactly one transaction and one `clear_credit`.
- Reset mid-payout: assert `rst` while `eject_nickel`=1. Expect:
  - all outputs 0 immediately; no `clear_credit`.
  - a fresh `dispense` edge after reset runs a full normal transaction.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: after a vend request, runs the drink motor for a fixed
// time, pays change coin by coin through a req/ack hopper handshake, then
// pulses clear_credit so the credit FSM can return to zero.
// Hopper handshake: a single eject request (dime or nickel) is held high in
// WAIT until hopper_ack is sampled high or the timeout expires; the request
// drops the cycle after, and REQ inserts at least one request-free cycle.
module change_dispenser #(
    parameter int PRICE_UNITS  = 6,
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dispense,
    input  logic       collect,
    input  logic [3:0] amount,
    input  logic       hopper_ack,
    output logic       vend_motor,
    output logic       eject_dime,
    output logic       eject_nickel,
    output logic       busy,
    output logic       clear_credit,
    output logic       change_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VEND = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] PRICE4     = 4'(PRICE_UNITS);

    state_t     state_q, state_d;
    logic       disp_q, disp_d;
    logic [3:0] change_q, change_d;
    logic [3:0] change_dec;
    logic [7:0] cnt_q, cnt_d;
    logic       dime_q, dime_d;
    logic       err_q, err_d;
    logic       motor_q, motor_d;
    logic       ej_dime_q, ej_dime_d;
    logic       ej_nick_q, ej_nick_d;
    logic       busy_q, busy_d;
    logic       clear_q, clear_d;

    // Remaining change after the current coin is acknowledged, floored at zero.
    always_comb begin
        change_dec = 4'd0;
        if (dime_q) begin
            change_dec = (change_q >= 4'd2) ? change_q - 4'd2 : 4'd0;
        end else begin
            change_dec = (change_q != 4'd0) ? change_q - 4'd1 : 4'd0;
        end
    end

    // Next-state logic; a vend starts only on a rising dispense edge in IDLE.
    always_comb begin
        state_d  = state_q;
        disp_d   = dispense;
        change_d = change_q;
        cnt_d    = cnt_q;
        dime_d   = dime_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (dispense && !disp_q) begin
                    state_d  = S_VEND;
                    cnt_d    = 8'd0;
                    err_d    = 1'b0;
                    change_d = 4'd0;
                    if (collect) begin
                        if (amount < PRICE4) begin
                            err_d = 1'b1;
                        end else begin
                            change_d = amount - PRICE4;
                        end
                    end
                end
            end
            S_VEND: begin
                if (cnt_q == MOTOR_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = (change_q != 4'd0) ? S_REQ : S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_REQ: begin
                dime_d  = (change_q >= 4'd2);
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack in the expiry cycle still counts the coin.
                if (hopper_ack) begin
                    change_d = change_dec;
                    cnt_d    = 8'd0;
                    state_d  = (change_dec != 4'd0) ? S_REQ : S_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    err_d    = 1'b1;
                    change_d = 4'd0;
                    cnt_d    = 8'd0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered Moore outputs, decoded from the next state.
    always_comb begin
        motor_d   = (state_d == S_VEND);
        ej_dime_d = (state_d == S_WAIT) && dime_d;
        ej_nick_d = (state_d == S_WAIT) && !dime_d;
        busy_d    = (state_d != S_IDLE);
        clear_d   = (state_d == S_DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            disp_q    <= 1'b0;
            change_q  <= 4'd0;
            cnt_q     <= 8'd0;
            dime_q    <= 1'b0;
            err_q     <= 1'b0;
            motor_q   <= 1'b0;
            ej_dime_q <= 1'b0;
            ej_nick_q <= 1'b0;
            busy_q    <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            disp_q    <= disp_d;
            change_q  <= change_d;
            cnt_q     <= cnt_d;
            dime_q    <= dime_d;
            err_q     <= err_d;
            motor_q   <= motor_d;
            ej_dime_q <= ej_dime_d;
            ej_nick_q <= ej_nick_d;
            busy_q    <= busy_d;
            clear_q   <= clear_d;
        end
    end

    assign vend_motor   = motor_q;
    assign eject_dime   = ej_dime_q;
    assign eject_nickel = ej_nick_q;
    assign busy         = busy_q;
    assign clear_credit = clear_q;
    assign change_err   = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed transactions push expected events
// (motor run length, each coin with its hold length, clear with error flag)
// into a queue; a monitor turns DUT output activity into events and compares.
module tb_change_dispenser;

    localparam logic [3:0] K_MOTOR = 4'h1;
    localparam logic [3:0] K_DIME  = 4'h2;
    localparam logic [3:0] K_NICK  = 4'h3;
    localparam logic [3:0] K_CLEAR = 4'h4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dispense;
    logic       collect;
    logic [3:0] amount;
    logic       hopper_ack;
    logic       vend_motor;
    logic       eject_dime;
    logic       eject_nickel;
    logic       busy;
    logic       clear_credit;
    logic       change_err;

    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int ack_delay = 1;

    change_dispenser dut (
        .clk         (clk),
        .rst         (rst),
        .dispense    (dispense),
        .collect     (collect),
        .amount      (amount),
        .hopper_ack  (hopper_ack),
        .vend_motor  (vend_motor),
        .eject_dime  (eject_dime),
        .eject_nickel(eject_nickel),
        .busy        (busy),
        .clear_credit(clear_credit),
        .change_err  (change_err)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [3:0] kind, input int val);
        exp_q.push_back({kind, 12'(val)});
    endtask

    task automatic emit(input logic [15:0] ev);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got 0x%0h want none", ev);
        end else begin
            e = exp_q.pop_front();
            check("event", ev, e);
        end
    endtask

    task automatic start_vend(input logic [3:0] amt, input logic col);
        @(negedge clk);
        amount   = amt;
        collect  = col;
        dispense = 1'b1;
        @(negedge clk);
        dispense = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 want busy=0 within 2000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_motor"}, vend_motor, 0);
        check({name, "_dime"}, eject_dime, 0);
        check({name, "_nickel"}, eject_nickel, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_clear"}, clear_credit, 0);
        check({name, "_err"}, change_err, 0);
    endtask

    // hopper model: acks a held request in its ack_delay-th cycle (0 = never)
    initial begin
        int hcnt;
        hcnt = 0;
        hopper_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !(eject_dime || eject_nickel)) hcnt = 0;
            else hcnt++;
            hopper_ack = (!rst && ack_delay > 0 && hcnt == ack_delay);
        end
    end

    // monitor: converts output activity into events for the scoreboard
    initial begin
        int m_len, d_len, n_len;
        logic p_m, p_d, p_n;
        m_len = 0; d_len = 0; n_len = 0;
        p_m = 0; p_d = 0; p_n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_len = 0; d_len = 0; n_len = 0;
                p_m = 0; p_d = 0; p_n = 0;
            end else begin
                if (eject_dime || eject_nickel) check("eject_exclusive", eject_dime && eject_nickel, 0);
                if (vend_motor) m_len++;
                else if (p_m) begin emit({K_MOTOR, 12'(m_len)}); m_len = 0; end
                if (eject_dime) d_len++;
                else if (p_d) begin emit({K_DIME, 12'(d_len)}); d_len = 0; end
                if (eject_nickel) n_len++;
                else if (p_n) begin emit({K_NICK, 12'(n_len)}); n_len = 0; end
                if (clear_credit) emit({K_CLEAR, 11'd0, change_err});
                p_m = vend_motor;
                p_d = eject_dime;
                p_n = eject_nickel;
            end
        end
    end

    // directed stimulus
    initial begin
        int lat;
        bit seen;
        rst = 1'b1;
        dispense = 1'b0;
        collect = 1'b0;
        amount = 4'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // exact credit: no change, clear at N+9, busy gone at N+10
        push_ev(K_MOTOR, 8); push_ev(K_CLEAR, 0);
        amount = 4'd6; collect = 1'b0; dispense = 1'b1;
        @(negedge clk);
        dispense = 1'b0;
        check("t1_busy_n1", busy, 1);
        check("t1_motor_n1", vend_motor, 1);
        lat = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (clear_credit) begin seen = 1; break; end
            @(negedge clk);
            lat++;
        end
        check("t1_clear_seen", seen, 1);
        check("t1_clear_latency", lat, 9);
        check("t1_err", change_err, 0);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        wait_idle();

        // 35c: one nickel held 3 cycles
        ack_delay = 3;
        push_ev(K_MOTOR, 8); push_ev(K_NICK, 3); push_ev(K_CLEAR, 0);
        start_vend(4'd7, 1'b1);
        wait_idle();

        // 50c: two dimes, immediate acks
        ack_delay = 1;
        push_ev(K_MOTOR, 8); push_ev(K_DIME, 1); push_ev(K_DIME, 1); push_ev(K_CLEAR, 0);
        start_vend(4'd10, 1'b1);
        wait_idle();

        // 45c: dime then nickel
        ack_delay = 2;
        push_ev(K_MOTOR, 8); push_ev(K_DIME, 2); push_ev(K_NICK, 2); push_ev(K_CLEAR, 0);
        start_vend(4'd9, 1'b1);
        wait_idle();

        // maximum credit: change 9 = four dimes and a nickel
        ack_delay = 1;
        push_ev(K_MOTOR, 8);
        for (int i = 0; i < 4; i++) push_ev(K_DIME, 1);
        push_ev(K_NICK, 1); push_ev(K_CLEAR, 0);
        start_vend(4'd15, 1'b1);
        wait_idle();

        // underpaid with collect: no coins, error flagged
        push_ev(K_MOTOR, 8); push_ev(K_CLEAR, 1);
        start_vend(4'd3, 1'b1);
        wait_idle();
        check("t6_err_sticky", change_err, 1);

        // hopper stall: dime held for the full timeout
        ack_delay = 0;
        push_ev(K_MOTOR, 8); push_ev(K_DIME, 255); push_ev(K_CLEAR, 1);
        start_vend(4'd8, 1'b1);
        wait_idle();
        repeat (10) @(negedge clk);
        check("t7_err_sticky", change_err, 1);

        // retrigger/hold: one transaction only; vend start clears the error
        ack_delay = 1;
        push_ev(K_MOTOR, 8); push_ev(K_CLEAR, 0);
        @(negedge clk);
        amount = 4'd6; collect = 1'b0; dispense = 1'b1;
        @(negedge clk);
        check("t8_err_cleared", change_err, 0);
        repeat (2) @(negedge clk);
        dispense = 1'b0;
        @(negedge clk);
        dispense = 1'b1;
        repeat (50) @(negedge clk);
        dispense = 1'b0;
        wait_idle();

        // reset during nickel payout: outputs drop at once, no clear
        ack_delay = 0;
        push_ev(K_MOTOR, 8);
        start_vend(4'd7, 1'b1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (eject_nickel) begin seen = 1; break; end
        end
        check("t9_nickel_seen", seen, 1);
        #1 rst = 1'b1;
        #1 check_all_zero("t9_reset");
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t9_idle_after_reset", busy, 0);
        ack_delay = 2;
        push_ev(K_MOTOR, 8); push_ev(K_NICK, 2); push_ev(K_CLEAR, 0);
        start_vend(4'd7, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
